// File: rtl/edfic_core_sink.sv
// Core-side sink of the EDFIC interrupt interface: admits the arbitration winner only if it is
// strictly more urgent than the running handler, runs the req/take handshake, tracks nesting.
module edfic_core_sink #(
  parameter int NrIrqs    = 4,
  parameter int DlWidth   = 24,
  parameter int NestDepth = 4,
  localparam int IdWidth  = $clog2(NrIrqs),
  localparam int DepthW   = $clog2(NestDepth + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [63:0]        mtime_i,
  input  logic               gie_i,
  input  logic               irq_valid_i,
  input  logic [IdWidth-1:0] irq_id_i,
  input  logic [DlWidth-1:0] irq_dl_i,
  output logic               irq_ack_o,
  output logic [IdWidth-1:0] irq_id_o,
  output logic               core_req_o,
  output logic [IdWidth-1:0] core_id_o,
  input  logic               core_take_i,
  input  logic               core_ret_i,
  output logic [DepthW-1:0]  depth_o,
  output logic [DlWidth-1:0] cur_dl_o,
  output logic               ret_err_o
);

  localparam int IdxW = (NestDepth > 1) ? $clog2(NestDepth) : 1;
  localparam logic [DepthW-1:0] MaxDepth = DepthW'(NestDepth);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  state_t               state_q, state_d;
  logic [IdWidth-1:0]   lat_id_q, lat_id_d;
  logic [DlWidth-1:0]   lat_cand_q, lat_cand_d;
  logic [DepthW-1:0]    depth_q;
  logic                 ret_err_q;
  logic [DlWidth-1:0]   stack_q [NestDepth];

  logic [DlWidth-1:0]   cand, top, diff;
  logic [IdxW-1:0]      top_idx, push_idx;
  logic                 admit, take, ret_pop;
  logic                 mtime_unused;

  assign mtime_unused = &{1'b0, mtime_i[63:DlWidth]};

  assign push_idx = depth_q[IdxW-1:0];
  assign top_idx  = IdxW'(depth_q - DepthW'(1));
  assign top      = (depth_q == '0) ? '0 : stack_q[top_idx];
  assign cand     = mtime_i[DlWidth-1:0] + irq_dl_i;
  // Sign of the modular difference keeps the urgency test correct across timer wrap.
  assign diff     = cand - top;
  assign admit    = irq_valid_i & gie_i & (depth_q < MaxDepth) &
                    ((depth_q == '0) | diff[DlWidth-1]);
  assign ret_pop  = core_ret_i & (depth_q != '0);

  always_comb begin
    state_d    = state_q;
    lat_id_d   = lat_id_q;
    lat_cand_d = lat_cand_q;
    take       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (admit) begin
          lat_id_d   = irq_id_i;
          lat_cand_d = cand;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (core_take_i) begin
          take    = 1'b1;
          state_d = S_ACK;
        end else if (!admit) begin
          state_d = S_IDLE;
        end else if (irq_id_i != lat_id_q) begin
          lat_id_d   = irq_id_i;
          lat_cand_d = cand;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      lat_id_q   <= '0;
      lat_cand_q <= '0;
      depth_q    <= '0;
      ret_err_q  <= 1'b0;
      for (int i = 0; i < NestDepth; i++) stack_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      lat_id_q   <= lat_id_d;
      lat_cand_q <= lat_cand_d;
      // A return and a take in the same cycle replace the top entry in place.
      if (take && ret_pop) begin
        stack_q[top_idx] <= lat_cand_q;
      end else if (take && (depth_q < MaxDepth)) begin
        stack_q[push_idx] <= lat_cand_q;
        depth_q           <= depth_q + DepthW'(1);
      end else if (ret_pop) begin
        depth_q <= depth_q - DepthW'(1);
      end
      if (core_ret_i && (depth_q == '0)) ret_err_q <= 1'b1;
    end
  end

  assign core_req_o = (state_q == S_REQ);
  assign core_id_o  = lat_id_q;
  assign irq_ack_o  = (state_q == S_ACK);
  assign irq_id_o   = (state_q == S_ACK) ? lat_id_q : '0;
  assign depth_o    = depth_q;
  assign cur_dl_o   = top;
  assign ret_err_o  = ret_err_q;

endmodule
